// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised input, start bit validated at mid-bit, data and stop sampled at bit centres.
// Latency ~4 + HALF + 9*CLOCKS_PER_BIT clocks from start edge to data_valid; no backpressure, outputs are single-cycle pulses.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 217
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       receiving,
    output logic       framing_error
);

    localparam int            CW   = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF = CW'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          sync1_q, sync2_q;
    logic          rx_s;

    // Synchroniser flops reset high so the idle line is not mistaken for a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line that is high again at mid-start was a glitch.
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_HIGH: begin
                // Hold off until a break condition ends, so a long low is not seen as new frames.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign receiving     = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx: a bit-banged line driver plus a queue-based model of received bytes.
module tb_uart_rx;

    localparam int CPB  = 217;
    localparam int HALF = (CPB - 1) / 2;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       receiving;
    logic       framing_error;

    always #20 clock = ~clock;

    uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .serial_in    (serial_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .receiving    (receiving),
        .framing_error(framing_error)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    logic [7:0] dv_q[$];
    int         dv_cyc_q[$];
    logic       dv_recv_q[$];
    int         ferr_cnt    = 0;
    int         overlap_cnt = 0;
    logic       recv_seen   = 1'b0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (data_valid === 1'b1) begin
            dv_q.push_back(data_out);
            dv_cyc_q.push_back(cyc);
            dv_recv_q.push_back(receiving);
        end
        if (framing_error === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (data_valid === 1'b1 && framing_error === 1'b1) overlap_cnt = overlap_cnt + 1;
        if (receiving === 1'b1) recv_seen = 1'b1;
    end

    function automatic logic [7:0] got_byte(input int i);
        if (i < dv_q.size()) return dv_q[i];
        return 8'hxx;
    endfunction

    task automatic clear_mon();
        dv_q.delete();
        dv_cyc_q.delete();
        dv_recv_q.delete();
        ferr_cnt  = 0;
        recv_seen = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        @(posedge clock);
        serial_in = v;
        repeat (CPB - 1) @(posedge clock);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clock);
        serial_in = 1'b0;
        t0 = cyc;
        repeat (CPB - 1) @(posedge clock);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic test_reset();
        #5 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL reset_receiving: got %b expected 0", receiving); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing_error: got %b expected 0", framing_error); end
        @(negedge clock);
        reset = 1'b1;
        idle_bits(1);
    endtask

    task automatic test_loopback();
        int lat;
        clear_mon();
        send_frame(8'h3F, 1'b1);
        idle_bits(1);
        lat = (dv_cyc_q.size() > 0) ? dv_cyc_q[0] - t0 - 1 : -1;
        checks++; if (dv_q.size() !== 1) begin errors++; $display("FAIL loop_pulses: got %0d expected 1", dv_q.size()); end
        checks++; if (got_byte(0) !== 8'h3F) begin errors++; $display("FAIL loop_data: got %h expected 3f", got_byte(0)); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL loop_ferr: got %0d expected 0", ferr_cnt); end
        checks++; if (dv_recv_q.size() == 0 || dv_recv_q[0] !== 1'b0) begin errors++; $display("FAIL loop_recv_fall: receiving not low in data_valid cycle"); end
        // Synchroniser and the IDLE detection edge sit on top of the nominal figure.
        checks++; if (lat < 2 + HALF + 9 * CPB - 1 || lat > 2 + HALF + 9 * CPB + 3) begin errors++; $display("FAIL loop_latency: got %0d expected about %0d", lat, 2 + HALF + 9 * CPB); end
    endtask

    task automatic test_pattern_sweep();
        logic [7:0] pats[6];
        pats = '{8'h00, 8'hFF, 8'h55, 8'hA5, 8'h01, 8'h80};
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            send_frame(pats[i], 1'b1);
            idle_bits(1);
        end
        checks++; if (dv_q.size() !== 6) begin errors++; $display("FAIL sweep_pulses: got %0d expected 6", dv_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got_byte(i) !== pats[i]) begin errors++; $display("FAIL sweep_data[%0d]: got %h expected %h", i, got_byte(i), pats[i]); end
        end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL sweep_ferr: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(posedge clock);
        serial_in = 1'b0;
        repeat (50) @(posedge clock);
        serial_in = 1'b1;
        repeat (CPB) @(posedge clock);
        @(negedge clock);
        checks++; if (recv_seen !== 1'b1) begin errors++; $display("FAIL glitch_recv_pulse: got %b expected 1", recv_seen); end
        checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL glitch_recv_after: got %b expected 0", receiving); end
        checks++; if (dv_q.size() !== 0 || ferr_cnt !== 0) begin errors++; $display("FAIL glitch_no_output: got %0d valid %0d ferr expected 0 0", dv_q.size(), ferr_cnt); end
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        checks++; if (dv_q.size() !== 1 || got_byte(0) !== 8'h3C) begin errors++; $display("FAIL glitch_next_frame: got %0d pulses data %h expected 1 pulse data 3c", dv_q.size(), got_byte(0)); end
    endtask

    task automatic test_framing_error();
        clear_mon();
        send_frame(8'h96, 1'b0);
        repeat (3 * CPB) @(posedge clock);
        @(negedge clock);
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cnt); end
        checks++; if (dv_q.size() !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 0", dv_q.size()); end
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL ferr_data_hold: got %h expected 3c", data_out); end
        checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL ferr_break_hold: got receiving %b expected 0", receiving); end
        idle_bits(2);
        send_frame(8'h12, 1'b1);
        idle_bits(1);
        checks++; if (dv_q.size() !== 1 || got_byte(0) !== 8'h12) begin errors++; $display("FAIL ferr_next_frame: got %0d pulses data %h expected 1 pulse data 12", dv_q.size(), got_byte(0)); end
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL ferr_total: got %0d expected 1", ferr_cnt); end
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_mon();
        send_frame(8'hA5, 1'b1);
        send_frame(8'h5A, 1'b1);
        idle_bits(1);
        gap = (dv_cyc_q.size() == 2) ? dv_cyc_q[1] - dv_cyc_q[0] : -1;
        checks++; if (dv_q.size() !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", dv_q.size()); end
        checks++; if (got_byte(0) !== 8'hA5 || got_byte(1) !== 8'h5A) begin errors++; $display("FAIL b2b_data: got %h %h expected a5 5a", got_byte(0), got_byte(1)); end
        checks++; if (gap < 10 * CPB - 1 || gap > 10 * CPB + 1) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", gap, 10 * CPB); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h3F;
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        @(posedge clock);
        serial_in = b[4];
        repeat (CPB / 2) @(posedge clock);
        #5;
        checks++; if (receiving !== 1'b1) begin errors++; $display("FAIL rst_mid_active: got receiving %b expected 1", receiving); end
        reset = 1'b0;
        #1;
        checks++; if (data_out !== 8'h00 || data_valid !== 1'b0 || receiving !== 1'b0 || framing_error !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got %h %b %b %b expected 00 0 0 0", data_out, data_valid, receiving, framing_error);
        end
        repeat (3) @(posedge clock);
        serial_in = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        idle_bits(2);
        checks++; if (dv_q.size() !== 0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d expected 0", dv_q.size()); end
        send_frame(8'hC3, 1'b1);
        idle_bits(1);
        checks++; if (dv_q.size() !== 1 || got_byte(0) !== 8'hC3) begin errors++; $display("FAIL rst_mid_next_frame: got %0d pulses data %h expected 1 pulse data c3", dv_q.size(), got_byte(0)); end
    endtask

    task automatic test_random_frames();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            idle_bits(int'($urandom_range(0, 2)));
        end
        idle_bits(1);
        checks++; if (dv_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_pulses: got %0d expected %0d", dv_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_byte(i) !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got_byte(i), exp_q[i]); end
        end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL rand_ferr: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_exclusive_pulses();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL valid_ferr_overlap: got %0d cycles expected 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_pattern_sweep();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        test_exclusive_pulses();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
